branch_predictor: RTL and testbench

- Dynamic branch predictor feeding the `predicted` bit that travels down the pipeline to the execute stage.
- Holds a table of 2-bit saturating counters indexed by the word-addressed PC. Gives a same-cycle prediction for the fetch/decode lookup.
- Trains from the execute stage's resolved outcome (branch decision, prediction, mispredict).
- Keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_predictor.sv | 102 ++++++++++
 tb/tb_branch_predictor.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Two-bit saturating-counter branch predictor with same-cycle lookup and
// resolve-time training. Define BRANCH_PREDICTOR_GSHARE_EN for gshare indexing.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   pd_pc,
  input  logic                  pd_valid,
  output logic                  predicted,
  output logic [INDEX_BITS-1:0] pd_ghr,
  input  logic                  upd_valid,
  input  logic [PC_WIDTH-1:0]   upd_pc,
  input  logic                  upd_taken,
  input  logic                  upd_predicted,
  input  logic [INDEX_BITS-1:0] upd_ghr,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0][1:0]  table_reg;
  logic [ENTRIES-1:0][1:0]  table_next;
  logic [INDEX_BITS-1:0]    lookup_idx;
  logic [INDEX_BITS-1:0]    upd_idx;
  logic [31:0]              branch_count_reg;
  logic [31:0]              branch_count_next;
  logic [31:0]              mispredict_count_reg;
  logic [31:0]              mispredict_count_next;
  logic                     unused_bits;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [INDEX_BITS-1:0]    ghr_reg;
  logic [INDEX_BITS-1:0]    ghr_next;

  assign lookup_idx = pd_pc[INDEX_BITS-1:0] ^ ghr_reg;
  assign upd_idx    = upd_pc[INDEX_BITS-1:0] ^ upd_ghr;
  assign ghr_next   = upd_valid ? {ghr_reg[INDEX_BITS-2:0], upd_taken} : ghr_reg;
  assign pd_ghr     = rst ? '0 : ghr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_reg <= '0;
    end else begin
      ghr_reg <= ghr_next;
    end
  end

  assign unused_bits = ^{pd_pc[PC_WIDTH-1:INDEX_BITS], upd_pc[PC_WIDTH-1:INDEX_BITS]};
`else
  assign lookup_idx  = pd_pc[INDEX_BITS-1:0];
  assign upd_idx     = upd_pc[INDEX_BITS-1:0];
  assign pd_ghr      = '0;
  // Snapshot port is kept so the pipeline interface matches the gshare build.
  assign unused_bits = ^{pd_pc[PC_WIDTH-1:INDEX_BITS], upd_pc[PC_WIDTH-1:INDEX_BITS], upd_ghr};
`endif

  // No bypass: a same-cycle update becomes visible only after the edge.
  assign predicted = pd_valid & ~rst & table_reg[lookup_idx][1];

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic hit;
      assign hit = upd_valid && (upd_idx == INDEX_BITS'(gi));
      assign table_next[gi] =
          !hit      ? table_reg[gi] :
          upd_taken ? ((table_reg[gi] == 2'b11) ? 2'b11 : table_reg[gi] + 2'd1) :
                      ((table_reg[gi] == 2'b00) ? 2'b00 : table_reg[gi] - 2'd1);
    end
  endgenerate

  always_comb begin
    branch_count_next     = branch_count_reg;
    mispredict_count_next = mispredict_count_reg;
    if (upd_valid) begin
      if (branch_count_reg != 32'hFFFF_FFFF) begin
        branch_count_next = branch_count_reg + 32'd1;
      end
      if ((upd_taken != upd_predicted) && (mispredict_count_reg != 32'hFFFF_FFFF)) begin
        mispredict_count_next = mispredict_count_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      table_reg            <= {ENTRIES{2'b01}};
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      table_reg            <= table_next;
      branch_count_reg     <= branch_count_next;
      mispredict_count_reg <= mispredict_count_next;
    end
  end

  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expected predictions are queued at
// drive time and popped when the combinational output is sampled.
module tb_branch_predictor;

  localparam int IB = 4;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pd_pc = '0;
  logic          pd_valid = 1'b0;
  logic          predicted;
  logic [IB-1:0] pd_ghr;
  logic          upd_valid = 1'b0;
  logic [PW-1:0] upd_pc = '0;
  logic          upd_taken = 1'b0;
  logic          upd_predicted = 1'b0;
  logic [IB-1:0] upd_ghr = '0;
  logic [31:0]   branch_count;
  logic [31:0]   mispredict_count;

  branch_predictor #(.INDEX_BITS(IB), .PC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .pd_pc(pd_pc), .pd_valid(pd_valid), .predicted(predicted),
    .pd_ghr(pd_ghr), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_predicted(upd_predicted), .upd_ghr(upd_ghr), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [1:0]    m_table [16];
  logic [31:0]   m_branch;
  logic [31:0]   m_misp;
  logic [IB-1:0] m_ghr;
  logic          exp_q [$];
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_table[i] = 2'b01;
    m_branch = 0;
    m_misp   = 0;
    m_ghr    = '0;
  endtask

  // One clock transaction: drive at negedge, check outputs, then advance model at posedge.
  task automatic step(input bit r, input bit pv, input logic [31:0] ppc,
                      input bit uv, input logic [31:0] upc, input bit ut,
                      input bit up, input logic [IB-1:0] ug);
    logic [IB-1:0] li;
    logic [IB-1:0] ui;
    logic          exp_pred;
    @(negedge clk);
    rst = r; pd_valid = pv; pd_pc = ppc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_predicted = up; upd_ghr = ug;
    li = ppc[IB-1:0];
    ui = upc[IB-1:0];
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    li = li ^ m_ghr;
    ui = ui ^ ug;
`endif
    exp_q.push_back(r ? 1'b0 : (pv & m_table[li][1]));
    #1;
    if (exp_q.size() == 0) check("queue_empty", 32'd1, 32'd0);
    else begin
      exp_pred = exp_q.pop_front();
      check("predicted", {31'd0, predicted}, {31'd0, exp_pred});
    end
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    check("pd_ghr", {28'd0, pd_ghr}, r ? 32'd0 : {28'd0, m_ghr});
`else
    check("pd_ghr", {28'd0, pd_ghr}, 32'd0);
`endif
    check("branch_count", branch_count, m_branch);
    check("mispredict_count", mispredict_count, m_misp);
    $display("txn rst=%0b pd_valid=%0b pd_pc=%0h predicted=%0b upd_valid=%0b upd_pc=%0h taken=%0b pred=%0b br=%0d misp=%0d",
             r, pv, ppc, predicted, uv, upc, ut, up, branch_count, mispredict_count);
    @(posedge clk);
    if (r) model_reset();
    else if (uv) begin
      if (ut && m_table[ui] != 2'b11) m_table[ui] = m_table[ui] + 2'd1;
      if (!ut && m_table[ui] != 2'b00) m_table[ui] = m_table[ui] - 2'd1;
      m_branch = m_branch + 1;
      if (ut != up) m_misp = m_misp + 1;
      m_ghr = {m_ghr[IB-2:0], ut};
    end
  endtask

  initial begin
    model_reset();
    // Reset, then a lookup at pc 0
    step(1, 1, 32'h0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h5, 1, 32'h5, 1, 0, 0);
    step(0, 1, 32'h0, 0, 0, 0, 0, 0);
    check("reset_pred_pc0", {31'd0, predicted}, 32'd0);
    // Saturate up at pc 5, then walk back down
    step(0, 1, 32'h5, 1, 32'h5, 1, 0, 0);
    step(0, 1, 32'h5, 0, 0, 0, 0, 0);
    check("first_misp", mispredict_count, 32'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h5, 1, 32'h5, 1, 1, 0);
    step(0, 1, 32'h5, 1, 32'h5, 0, 1, 0);
    step(0, 1, 32'h5, 1, 32'h5, 0, 1, 0);
    step(0, 1, 32'h5, 0, 0, 0, 0, 0);
    // Aliasing: pc 0x13 shares entry 3
    step(0, 0, 32'h0, 1, 32'h3, 1, 0, 0);
    step(0, 0, 32'h0, 1, 32'h3, 1, 1, 0);
    step(0, 1, 32'h13, 0, 0, 0, 0, 0);
    step(0, 1, 32'h4, 0, 0, 0, 0, 0);
    step(0, 0, 32'h3, 0, 0, 0, 0, 0);
    // Same-cycle lookup and update of pc 7
    step(0, 1, 32'h7, 1, 32'h7, 1, 0, 0);
    step(0, 1, 32'h7, 0, 0, 0, 0, 0);
    // Reset mid-operation with a concurrent taken update
    step(0, 0, 32'h0, 1, 32'h5, 1, 1, 0);
    step(1, 1, 32'h5, 1, 32'h5, 1, 0, 0);
    step(0, 1, 32'h5, 0, 0, 0, 0, 0);
    check("mid_reset_branch", branch_count, 32'd0);
    check("mid_reset_misp", mispredict_count, 32'd0);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 32'h2, 1, 0, 0);
    step(0, 1, 32'h2, 0, 0, 0, 0, 0);
    check("gshare_ghr", {28'd0, pd_ghr}, 32'h7);
    check("gshare_pred", {31'd0, predicted}, 32'd0);
`endif
    // Random traffic over a small PC range to exercise saturation both ways
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 31),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1), IB'($urandom_range(0, 15)));
    end
    step(0, 0, 32'h0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
